// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter, one-entry rd output stage and in-flight forwarding
// Optional feature: REGFILE_ARB_RR_EN selects round-robin arbitration (default fixed priority).
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*5-1:0]    i_req_waddr,
    input  logic [NREQ*XLEN-1:0] i_req_wdata,
    output logic [4:0]           o_rd_waddr,
    output logic [XLEN-1:0]      o_rd_wdata,
    input  logic [4:0]           i_rs1_raddr,
    input  logic [4:0]           i_rs2_raddr,
    output logic                 o_rs1_fwd,
    output logic                 o_rs2_fwd,
    output logic [XLEN-1:0]      o_fwd_data,
    output logic                 o_contention
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [4:0]      sel_waddr;
    logic [XLEN-1:0] sel_wdata;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      valid_cnt;

`ifdef REGFILE_ARB_RR_EN
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] gnt_idx;
    int              cand;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        grant     = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        cand      = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!gnt_any && i_req_valid[cand]) begin
                gnt_any     = 1'b1;
                gnt_idx     = IDXW'(cand);
                grant[cand] = 1'b1;
                sel_waddr   = i_req_waddr[5*cand +: 5];
                sel_wdata   = i_req_wdata[XLEN*cand +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant     = '0;
        gnt_any   = 1'b0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && i_req_valid[i]) begin
                gnt_any   = 1'b1;
                grant[i]  = 1'b1;
                sel_waddr = i_req_waddr[5*i +: 5];
                sel_wdata = i_req_wdata[XLEN*i +: XLEN];
            end
        end
    end
`endif

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            valid_cnt = valid_cnt + {3'b000, i_req_valid[i]};
        end
    end

    assign o_contention = (valid_cnt > 4'd1);
    assign o_req_ready  = rstn ? grant : '0;

    // Data holds when idle; only the address signals a write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            waddr_q <= sel_waddr;
            wdata_q <= sel_wdata;
        end else begin
            waddr_q <= '0;
        end
    end

    // Gating by reset keeps an in-flight write from reaching the regfile while reset is held.
    assign o_rd_waddr = rstn ? waddr_q : 5'd0;
    assign o_rd_wdata = wdata_q;
    assign o_fwd_data = wdata_q;
    assign o_rs1_fwd  = (o_rd_waddr != 5'd0) && (i_rs1_raddr == o_rd_waddr);
    assign o_rs2_fwd  = (o_rd_waddr != 5'd0) && (i_rs2_raddr == o_rd_waddr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_waddr;
    logic [NREQ*XLEN-1:0] req_wdata;
    logic [4:0]           rd_waddr;
    logic [XLEN-1:0]      rd_wdata;
    logic [4:0]           rs1_raddr;
    logic [4:0]           rs2_raddr;
    logic                 rs1_fwd;
    logic                 rs2_fwd;
    logic [XLEN-1:0]      fwd_data;
    logic                 contention;

    logic [XLEN-1:0]      rf [32];
    int                   errors = 0;
    int                   checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_waddr  (req_waddr),
        .i_req_wdata  (req_wdata),
        .o_rd_waddr   (rd_waddr),
        .o_rd_wdata   (rd_wdata),
        .i_rs1_raddr  (rs1_raddr),
        .i_rs2_raddr  (rs2_raddr),
        .o_rs1_fwd    (rs1_fwd),
        .o_rs2_fwd    (rs2_fwd),
        .o_fwd_data   (fwd_data),
        .o_contention (contention)
    );

    // Register file model fed by the arbiter's write port.
    always @(posedge clk) begin
        if (rd_waddr != 5'd0) rf[rd_waddr] <= rd_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 3'b111; rs1_raddr = 5'd0; rs2_raddr = 5'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_waddr[5*i +: 5]       = 5'(i + 1);
            req_wdata[XLEN*i +: XLEN] = 32'h100 + i;
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
            checks++; if (rd_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", rd_waddr); end
            checks++; if (rd_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", rd_wdata); end
        end
        rstn = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
        checks++; if (contention !== 1'b1) begin errors++; $display("FAIL reset_contention: got %b expected 1", contention); end
        req_valid = 3'b000;
        #1;
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL idle_contention: got %b expected 0", contention); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready: got %b expected 000", req_ready); end
        tick();
    endtask

    task automatic test_single();
        req_valid = 3'b010;
        req_waddr[5 +: 5]     = 5'd5;
        req_wdata[32 +: 32]   = 32'hDEADBEEF;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", req_ready); end
        checks++; if (contention !== 1'b0) begin errors++; $display("FAIL single_contention: got %b expected 0", contention); end
        tick();
        req_valid = 3'b000;
        checks++; if (rd_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d expected 5", rd_waddr); end
        checks++; if (rd_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: got %h expected deadbeef", rd_wdata); end
        tick();
        checks++; if (rd_waddr !== 5'd0) begin errors++; $display("FAIL single_idle_waddr: got %0d expected 0", rd_waddr); end
        checks++; if (rd_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_wdata: got %h expected deadbeef", rd_wdata); end
        checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_regfile: got %h expected deadbeef", rf[5]); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_rdy;
        int              g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_waddr[5*i +: 5]       = 5'(i + 1);
            req_wdata[XLEN*i +: XLEN] = 32'hA000 + i;
        end
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
`ifdef REGFILE_ARB_RR_EN
            g = c % NREQ;
`else
            g = 0;
`endif
            exp_rdy = 3'b001 << g;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
            checks++; if (contention !== 1'b1) begin errors++; $display("FAIL contention_flag[%0d]: got %b expected 1", c, contention); end
            tick();
            checks++; if (rd_waddr !== 5'(g + 1)) begin errors++; $display("FAIL contention_waddr[%0d]: got %0d expected %0d", c, rd_waddr, g + 1); end
            checks++; if (rd_wdata !== 32'hA000 + g) begin errors++; $display("FAIL contention_wdata[%0d]: got %h expected %h", c, rd_wdata, 32'hA000 + g); end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_forward();
        req_valid = 3'b100;
        req_waddr[10 +: 5]  = 5'd7;
        req_wdata[64 +: 32] = 32'h1234;
        tick();
        // new grant to x8 in the same cycle x7 is being forwarded
        req_valid = 3'b001;
        req_waddr[0 +: 5]  = 5'd8;
        req_wdata[0 +: 32] = 32'h5555;
        rs1_raddr = 5'd7; rs2_raddr = 5'd7;
        #1;
        checks++; if (rs1_fwd !== 1'b1 || rs2_fwd !== 1'b1) begin errors++; $display("FAIL fwd_both: got %b%b expected 11", rs1_fwd, rs2_fwd); end
        checks++; if (fwd_data !== 32'h1234) begin errors++; $display("FAIL fwd_data: got %h expected 1234", fwd_data); end
        rs1_raddr = 5'd8;
        #1;
        checks++; if (rs1_fwd !== 1'b0 || rs2_fwd !== 1'b1) begin errors++; $display("FAIL fwd_vs_new_grant: got %b%b expected 01", rs1_fwd, rs2_fwd); end
        tick();
        req_valid = 3'b000;
        #1;
        checks++; if (rs1_fwd !== 1'b1 || rs2_fwd !== 1'b0) begin errors++; $display("FAIL fwd_x8: got %b%b expected 10", rs1_fwd, rs2_fwd); end
        checks++; if (fwd_data !== 32'h5555) begin errors++; $display("FAIL fwd_data_x8: got %h expected 5555", fwd_data); end
        tick();
        checks++; if (rs1_fwd !== 1'b0 || rs2_fwd !== 1'b0) begin errors++; $display("FAIL fwd_idle: got %b%b expected 00", rs1_fwd, rs2_fwd); end
        checks++; if (rf[7] !== 32'h1234 || rf[8] !== 32'h5555) begin errors++; $display("FAIL fwd_regfile: got %h/%h expected 1234/5555", rf[7], rf[8]); end
    endtask

    task automatic test_x0();
        req_valid = 3'b001;
        req_waddr[0 +: 5]  = 5'd0;
        req_wdata[0 +: 32] = 32'hFFFF_FFFF;
        rs1_raddr = 5'd0; rs2_raddr = 5'd0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b expected 001", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (rd_waddr !== 5'd0) begin errors++; $display("FAIL x0_waddr: got %0d expected 0", rd_waddr); end
        checks++; if (rd_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL x0_wdata: got %h expected ffffffff", rd_wdata); end
        checks++; if (rs1_fwd !== 1'b0 || rs2_fwd !== 1'b0) begin errors++; $display("FAIL x0_fwd: got %b%b expected 00", rs1_fwd, rs2_fwd); end
        tick();
        checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL x0_regfile: got %h expected 0", rf[0]); end
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b001;
        req_waddr[0 +: 5]  = 5'd9;
        req_wdata[0 +: 32] = 32'h1111;
        tick();
        req_valid = 3'b000;
        tick();
        checks++; if (rf[9] !== 32'h1111) begin errors++; $display("FAIL mid_prewrite: got %h expected 1111", rf[9]); end
        req_valid = 3'b001;
        req_wdata[0 +: 32] = 32'h2222;
        tick();
        req_valid = 3'b000;
        checks++; if (rd_waddr !== 5'd9) begin errors++; $display("FAIL mid_inflight: got %0d expected 9", rd_waddr); end
        rstn = 1'b0;
        rs1_raddr = 5'd9;
        #1;
        checks++; if (rs1_fwd !== 1'b0) begin errors++; $display("FAIL mid_fwd_in_reset: got %b expected 0", rs1_fwd); end
        tick();
        checks++; if (rd_waddr !== 5'd0) begin errors++; $display("FAIL mid_waddr: got %0d expected 0", rd_waddr); end
        rstn = 1'b1;
        tick();
        checks++; if (rf[9] !== 32'h1111) begin errors++; $display("FAIL mid_regfile: got %h expected 1111", rf[9]); end
        checks++; if (rd_wdata !== 32'h0) begin errors++; $display("FAIL mid_wdata_cleared: got %h expected 0", rd_wdata); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        req_valid = '0; req_waddr = '0; req_wdata = '0;
        rs1_raddr = '0; rs2_raddr = '0; rstn = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_forward();
        test_x0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
